elevator_car_controller: RTL

ELEVATOR_CAR_CONTROLLER -- requirements
Module: elevator_car_controller

---
 rtl/elevator_car_controller.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/elevator_car_controller.sv
// Single-car elevator controller: serves queue_status requests with a SCAN policy.
// state     | meaning
// IDLE      | parked, choosing next direction from pending requests
// MOVE_UP   | travelling up one floor per TRAVEL_CYCLES
// MOVE_DOWN | travelling down one floor per TRAVEL_CYCLES
// ARRIVE    | one-cycle clear strobe for the floor just reached
// DOOR      | door held open, restarts if the floor is requested again
module elevator_car_controller #(
  parameter int FLOOR_COUNT   = 7,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FLOOR_COUNT-1:0] queue_status,
  output logic                   clear_valid,
  output logic [2:0]             clear_floor,
  output logic [2:0]             current_floor,
  output logic                   motor_up,
  output logic                   motor_down,
  output logic                   door_open,
  output logic                   dir_up
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MOVE_UP   = 3'd1;
  localparam logic [2:0] S_MOVE_DOWN = 3'd2;
  localparam logic [2:0] S_ARRIVE    = 3'd3;
  localparam logic [2:0] S_DOOR      = 3'd4;

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);
  localparam logic [2:0]    FLOOR_TOP   = 3'(FLOOR_COUNT - 1);

  logic [2:0]    state_q, state_d;
  logic [2:0]    floor_q, floor_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic here, above, below;
  logic here_up, above_up, here_dn, below_dn;

  // Request scan relative to the current floor and to the floor one step away.
  always_comb begin
    here     = 1'b0;
    above    = 1'b0;
    below    = 1'b0;
    here_up  = 1'b0;
    above_up = 1'b0;
    here_dn  = 1'b0;
    below_dn = 1'b0;
    for (int i = 0; i < FLOOR_COUNT; i++) begin
      if (i == int'(floor_q))     here     = here     | queue_status[i];
      if (i >  int'(floor_q))     above    = above    | queue_status[i];
      if (i <  int'(floor_q))     below    = below    | queue_status[i];
      if (i == int'(floor_q) + 1) here_up  = here_up  | queue_status[i];
      if (i >  int'(floor_q) + 1) above_up = above_up | queue_status[i];
      if (i + 1 == int'(floor_q)) here_dn  = here_dn  | queue_status[i];
      if (i + 1 <  int'(floor_q)) below_dn = below_dn | queue_status[i];
    end
  end

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        dcnt_d = '0;
        if (here) begin
          state_d = S_ARRIVE;
        end else if (dir_q) begin
          if (above) begin
            state_d = S_MOVE_UP;
          end else if (below) begin
            state_d = S_MOVE_DOWN;
            dir_d   = 1'b0;
          end
        end else begin
          if (below) begin
            state_d = S_MOVE_DOWN;
          end else if (above) begin
            state_d = S_MOVE_UP;
            dir_d   = 1'b1;
          end
        end
      end
      S_MOVE_UP: begin
        // Top-floor guard keeps current_floor in range even if the queue changes mid-trip.
        if (floor_q >= FLOOR_TOP) begin
          state_d = S_IDLE;
          tcnt_d  = '0;
        end else if (tcnt_q == TRAVEL_LAST) begin
          tcnt_d  = '0;
          floor_d = floor_q + 3'd1;
          if (here_up)       state_d = S_ARRIVE;
          else if (!above_up) state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_MOVE_DOWN: begin
        if (floor_q == 3'd0) begin
          state_d = S_IDLE;
          tcnt_d  = '0;
        end else if (tcnt_q == TRAVEL_LAST) begin
          tcnt_d  = '0;
          floor_d = floor_q - 3'd1;
          if (here_dn)       state_d = S_ARRIVE;
          else if (!below_dn) state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q - TW'(0) + TW'(1);
        end
      end
      S_ARRIVE: begin
        state_d = S_DOOR;
        dcnt_d  = '0;
      end
      S_DOOR: begin
        if (here) begin
          dcnt_d = '0;
        end else if (dcnt_q == DOOR_LAST) begin
          state_d = S_IDLE;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tcnt_d  = '0;
        dcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      floor_q <= 3'd0;
      dir_q   <= 1'b1;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      tcnt_q  <= tcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // A re-request while the door is open is acknowledged in the same cycle.
  assign clear_valid   = (state_q == S_ARRIVE) || ((state_q == S_DOOR) && here);
  assign clear_floor   = floor_q;
  assign current_floor = floor_q;
  assign motor_up      = (state_q == S_MOVE_UP);
  assign motor_down    = (state_q == S_MOVE_DOWN);
  assign door_open     = (state_q == S_DOOR);
  assign dir_up        = dir_q;

endmodule
